// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//   Bundles the two buses of the integer execution unit:
//     * issue bus from the reservation station (start_alu, operands, opcode,
//       destination tag) with back-pressure alu_full;
//     * result bus towards RS/LSB/ROB (alu_ready, tag, result, next PC) with
//       the cdb_grant acceptance strobe.
//   Modports:
//     slave  - the execution unit (consumes issue, produces results)
//     master - the environment (RS + result-bus arbiter)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface alu_exec_unit_if #(
   parameter int ROB_BIT = 4
) ();

   // issue side
   logic               start_alu;
   logic [31:0]        vi;
   logic [31:0]        vj;
   logic [31:0]        imm;
   logic [31:0]        inst_addr;
   logic [2:0]         op;
   logic [6:0]         op_type;
   logic               op_addition;
   logic [ROB_BIT-1:0] alu_rob_entry;
   logic               alu_full;

   // result side
   logic               alu_ready;
   logic               cdb_grant;
   logic [ROB_BIT-1:0] finished_alu_rob_entry;
   logic [31:0]        alu_result;
   logic [31:0]        next_pc;

   modport slave (
      input  start_alu, vi, vj, imm, inst_addr, op, op_type, op_addition,
             alu_rob_entry, cdb_grant,
      output alu_full, alu_ready, finished_alu_rob_entry, alu_result, next_pc
   );

   modport master (
      output start_alu, vi, vj, imm, inst_addr, op, op_type, op_addition,
             alu_rob_entry, cdb_grant,
      input  alu_full, alu_ready, finished_alu_rob_entry, alu_result, next_pc
   );

endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   RV32I integer execution unit. One instruction per cycle is latched into
//   the execute register E1; its result is computed combinationally and
//   written into a small in-order result queue on the following edge. The
//   queue head is broadcast on the result bus until cdb_grant pops it.
//
//   Ports:
//     clk_in        system clock
//     rst_in        asynchronous, active-low reset
//     rdy_in        CPU ready; low freezes all state
//     rob_clear_up  mispredict flush (highest priority, empties E1 + queue)
//     bus           alu_exec_unit_if.slave (issue bus + result bus)
//
//   Parameters:
//     ROB_BIT       width of ROB tags
//     QUEUE_DEPTH   result queue entries (power of 2, >= 2)
//
//   Build option:
//     ALU_BYPASS_EN - when defined, an E1 result facing an empty queue is
//                     presented on the result bus in the same cycle and is
//                     not enqueued if granted (1-edge latency).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_exec_unit #(
   parameter int ROB_BIT     = 4,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             rob_clear_up,
   alu_exec_unit_if.slave   bus
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W+1:0] FULL_LVL = (PTR_W+2)'(QUEUE_DEPTH);

   typedef struct packed {
      logic [ROB_BIT-1:0] tag;
      logic [31:0]        result;
      logic [31:0]        npc;
   } result_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic               e1_v;
   logic [31:0]        e1_vi, e1_vj, e1_imm, e1_pc;
   logic [2:0]         e1_op;
   logic [6:0]         e1_op_type;
   logic               e1_add;
   logic [ROB_BIT-1:0] e1_tag;

   result_t            queue_mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [PTR_W:0]     cnt_q, cnt_next;

   // Last value shown on the result bus; keeps the outputs stable once the
   // queue runs empty.
   result_t            last_q;

   // ------------------------------------------------------------------
   // Execute stage (combinational on E1)
   // ------------------------------------------------------------------
   logic [31:0] pc_plus4, pc_plus_imm, jalr_sum, sra_val;
   logic [4:0]  shamt;
   logic        taken;
   logic [31:0] exec_result, exec_npc;
   result_t     e1_out;

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      pc_plus4    = e1_pc + 32'd4;
      pc_plus_imm = e1_pc + e1_imm;
      jalr_sum    = e1_vi + e1_imm;
      shamt       = e1_vj[4:0];
      // Kept as a standalone statement: inside a ?: with unsigned operands
      // the arithmetic shift would silently degrade to a logical one.
      sra_val     = $signed(e1_vi) >>> shamt;
      taken       = 1'b0;
      exec_result = '0;
      exec_npc    = pc_plus4;

      case (e1_op_type)
         OPC_OP, OPC_OP_IMM: begin
            case (e1_op)
               3'b000: begin
                  // only register-register ops subtract; ADDI never does
                  if (e1_op_type == OPC_OP && e1_add) exec_result = e1_vi - e1_vj;
                  else                                exec_result = e1_vi + e1_vj;
               end
               3'b001: exec_result = e1_vi << shamt;
               3'b010: exec_result = {31'b0, $signed(e1_vi) < $signed(e1_vj)};
               3'b011: exec_result = {31'b0, e1_vi < e1_vj};
               3'b100: exec_result = e1_vi ^ e1_vj;
               3'b101: begin
                  if (e1_add) exec_result = sra_val;
                  else        exec_result = e1_vi >> shamt;
               end
               3'b110: exec_result = e1_vi | e1_vj;
               default: exec_result = e1_vi & e1_vj;
            endcase
         end
         OPC_LUI:   exec_result = e1_vj;
         OPC_AUIPC: exec_result = pc_plus_imm;
         OPC_BRANCH: begin
            case (e1_op)
               3'b000:  taken = (e1_vi == e1_vj);
               3'b001:  taken = (e1_vi != e1_vj);
               3'b100:  taken = ($signed(e1_vi) <  $signed(e1_vj));
               3'b101:  taken = ($signed(e1_vi) >= $signed(e1_vj));
               3'b110:  taken = (e1_vi <  e1_vj);
               3'b111:  taken = (e1_vi >= e1_vj);
               default: taken = 1'b0;
            endcase
            exec_result = {31'b0, taken};
            exec_npc    = taken ? pc_plus_imm : pc_plus4;
         end
         OPC_JAL: begin
            exec_result = pc_plus4;
            exec_npc    = pc_plus_imm;
         end
         OPC_JALR: begin
            exec_result = pc_plus4;
            exec_npc    = {jalr_sum[31:1], 1'b0};
         end
         default: begin
            exec_result = '0;
            exec_npc    = pc_plus4;
         end
      endcase
   end

   assign e1_out = '{tag: e1_tag, result: exec_result, npc: exec_npc};

   // ------------------------------------------------------------------
   // Queue control and result-bus view
   // ------------------------------------------------------------------
   logic [PTR_W+1:0] occupancy;
   logic             q_nonempty;
   logic             accept, push, q_pop, bypass_pop;
   logic             out_valid;
   result_t          out_view;

   // E1 counts against capacity: it is guaranteed a queue slot next edge.
   assign occupancy  = {1'b0, cnt_q} + {{(PTR_W+1){1'b0}}, e1_v};
   assign bus.alu_full = (occupancy >= FULL_LVL);
   assign q_nonempty = (cnt_q != '0);
   assign accept     = bus.start_alu && !bus.alu_full;
   assign q_pop      = q_nonempty && bus.cdb_grant;

`ifdef ALU_BYPASS_EN
   assign bypass_pop = !q_nonempty && e1_v && bus.cdb_grant;
   assign out_valid  = q_nonempty || e1_v;
   assign out_view   = q_nonempty ? queue_mem[head_q] : (e1_v ? e1_out : last_q);
`else
   assign bypass_pop = 1'b0;
   assign out_valid  = q_nonempty;
   assign out_view   = q_nonempty ? queue_mem[head_q] : last_q;
`endif

   assign push = e1_v && !bypass_pop;

   always_comb begin
      cnt_next = cnt_q;
      if (push && !q_pop)      cnt_next = cnt_q + CNT_ONE;
      else if (!push && q_pop) cnt_next = cnt_q - CNT_ONE;
   end

   assign bus.alu_ready              = out_valid;
   assign bus.finished_alu_rob_entry = out_view.tag;
   assign bus.alu_result             = out_view.result;
   assign bus.next_pc                = out_view.npc;

   // ------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         e1_v       <= 1'b0;
         e1_vi      <= '0;
         e1_vj      <= '0;
         e1_imm     <= '0;
         e1_pc      <= '0;
         e1_op      <= '0;
         e1_op_type <= '0;
         e1_add     <= 1'b0;
         e1_tag     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= '0;
         last_q     <= '0;
      end else if (rdy_in) begin
         // Whatever is on the bus when it is consumed or flushed becomes
         // the held value for an empty queue.
         if (out_valid && (rob_clear_up || bus.cdb_grant)) last_q <= out_view;

         if (rob_clear_up) begin
            e1_v   <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
         end else begin
            e1_v <= accept;
            if (accept) begin
               e1_vi      <= bus.vi;
               e1_vj      <= bus.vj;
               e1_imm     <= bus.imm;
               e1_pc      <= bus.inst_addr;
               e1_op      <= bus.op;
               e1_op_type <= bus.op_type;
               e1_add     <= bus.op_addition;
               e1_tag     <= bus.alu_rob_entry;
            end
            if (push)  tail_q <= tail_q + PTR_ONE;
            if (q_pop) head_q <= head_q + PTR_ONE;
            cnt_q <= cnt_next;
         end
      end
   end

   // NOTE: the queue storage has no reset; validity lives entirely in the
   // pointers and count, so stale slot contents are never observed.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !rob_clear_up && push) queue_mem[tail_q] <= e1_out;
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps

module tb_alu_exec_unit;

   localparam int ROB_BIT = 4;
   localparam int QD      = 4;

   localparam logic [6:0] K_OP     = 7'b0110011;
   localparam logic [6:0] K_OP_IMM = 7'b0010011;
   localparam logic [6:0] K_LUI    = 7'b0110111;
   localparam logic [6:0] K_AUIPC  = 7'b0010111;
   localparam logic [6:0] K_BRANCH = 7'b1100011;
   localparam logic [6:0] K_JAL    = 7'b1101111;
   localparam logic [6:0] K_JALR   = 7'b1100111;
   localparam logic [6:0] K_LOAD   = 7'b0000011;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic rob_clear_up;

   alu_exec_unit_if #(.ROB_BIT(ROB_BIT)) bus ();

   alu_exec_unit #(.ROB_BIT(ROB_BIT), .QUEUE_DEPTH(QD)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .rob_clear_up (rob_clear_up),
      .bus          (bus)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [ROB_BIT-1:0] tag;
      logic [31:0]        res;
      logic [31:0]        npc;
      int                 vis;   // first cycle index at which it is at the bus
   } exp_t;

   exp_t mq[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   // Architectural meaning of each RV32I instruction, written from the ISA.
   function automatic void ref_exec(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    input logic [2:0] f3, input logic [6:0] opc,
                                    input logic add,
                                    output logic [31:0] res, output logic [31:0] npc);
      int signed sa;
      int signed sb;
      bit        tk;
      sa  = a;
      sb  = b;
      tk  = 1'b0;
      res = 32'd0;
      npc = pc + 32'd4;
      if (opc == K_OP || opc == K_OP_IMM) begin
         case (f3)
            3'd0: res = (opc == K_OP && add) ? a - b : a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: begin
               if (add) res = sa >>> b[4:0];
               else     res = a >> b[4:0];
            end
            3'd6: res = a | b;
            default: res = a & b;
         endcase
      end else if (opc == K_LUI) begin
         res = b;
      end else if (opc == K_AUIPC) begin
         res = pc + imm;
      end else if (opc == K_BRANCH) begin
         case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = (sa < sb);
            3'd5: tk = (sa >= sb);
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
         endcase
         res = tk ? 32'd1 : 32'd0;
         npc = tk ? pc + imm : pc + 32'd4;
      end else if (opc == K_JAL) begin
         res = pc + 32'd4;
         npc = pc + imm;
      end else if (opc == K_JALR) begin
         res = pc + 32'd4;
         npc = (a + imm) & 32'hFFFF_FFFE;
      end
   endfunction

   task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [2:0] f3, input logic [6:0] opc, input logic add,
                        input logic [ROB_BIT-1:0] tag);
      bus.start_alu     = s;
      bus.vi            = a;
      bus.vj            = b;
      bus.imm           = imm;
      bus.inst_addr     = pc;
      bus.op            = f3;
      bus.op_type       = opc;
      bus.op_addition   = add;
      bus.alu_rob_entry = tag;
   endtask

   // One instruction with grant held high: invisible after the issue edge,
   // on the bus after the next edge, gone after the pop.
   task automatic run_single(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic [2:0] f3, input logic [6:0] opc, input logic add,
                             input logic [ROB_BIT-1:0] tag);
      logic [31:0] er, en;
      ref_exec(a, b, imm, pc, f3, opc, add, er, en);
      bus.cdb_grant = 1'b1;
      drive(1'b1, a, b, imm, pc, f3, opc, add, tag);
      tick();
      bus.start_alu = 1'b0;
      check({name, "_lat"}, 64'(bus.alu_ready), 64'd0);
      tick();
      check({name, "_rdy"}, 64'(bus.alu_ready), 64'd1);
      check({name, "_tag"}, 64'(bus.finished_alu_rob_entry), 64'(tag));
      check({name, "_res"}, 64'(bus.alu_result), 64'(er));
      check({name, "_npc"}, 64'(bus.next_pc), 64'(en));
      tick();
      check({name, "_pop"}, 64'(bus.alu_ready), 64'd0);
   endtask

   // Compare the bus with the in-order model for the current cycle.
   task automatic check_model(input string name);
      bit vis;
      vis = (mq.size() > 0) && (cyc >= mq[0].vis);
      check({name, "_ready"}, 64'(bus.alu_ready), 64'(vis));
      check({name, "_full"}, 64'(bus.alu_full), 64'(mq.size() >= QD));
      if (vis) begin
         check({name, "_tag"}, 64'(bus.finished_alu_rob_entry), 64'(mq[0].tag));
         check({name, "_res"}, 64'(bus.alu_result), 64'(mq[0].res));
         check({name, "_npc"}, 64'(bus.next_pc), 64'(mq[0].npc));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  opc_tab [8];
      logic [31:0] er, en;
      logic [31:0] ra, rb, ri, rp;
      logic [2:0]  rf;
      logic [6:0]  ro;
      logic        rad, rs, rg, vis;
      logic [ROB_BIT-1:0] rt;
      logic [31:0] sh_a;
      exp_t        e;

      opc_tab = '{K_OP, K_OP_IMM, K_LUI, K_AUIPC, K_BRANCH, K_JAL, K_JALR, K_LOAD};

      // ---------------- reset ----------------
      rst_in        = 1'b0;
      rdy_in        = 1'b1;
      rob_clear_up  = 1'b0;
      bus.cdb_grant = 1'b0;
      drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0);
      tick();
      tick();
      check("rst_ready", 64'(bus.alu_ready), 64'd0);
      check("rst_full", 64'(bus.alu_full), 64'd0);
      check("rst_tag", 64'(bus.finished_alu_rob_entry), 64'd0);
      check("rst_res", 64'(bus.alu_result), 64'd0);
      check("rst_npc", 64'(bus.next_pc), 64'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      tick();

      // ---------------- directed instructions ----------------
      run_single("add", 32'd5, 32'd7, 32'd0, 32'h40, 3'b000, K_OP, 1'b0, 4'd3);
      run_single("sub", 32'd1, 32'd2, 32'd0, 32'h44, 3'b000, K_OP, 1'b1, 4'd4);
      run_single("addi_nosub", 32'd1, 32'd2, 32'd0, 32'h48, 3'b000, K_OP_IMM, 1'b1, 4'd5);
      run_single("sra", 32'h8000_0000, 32'd4, 32'd0, 32'h4c, 3'b101, K_OP, 1'b1, 4'd6);
      run_single("srai", 32'hF000_1234, 32'd8, 32'd0, 32'h50, 3'b101, K_OP_IMM, 1'b1, 4'd7);
      run_single("srli", 32'hF000_1234, 32'd8, 32'd0, 32'h54, 3'b101, K_OP_IMM, 1'b0, 4'd8);
      run_single("slt", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h58, 3'b010, K_OP, 1'b0, 4'd9);
      run_single("sltu", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h5c, 3'b011, K_OP, 1'b0, 4'd10);
      run_single("bne", 32'd1, 32'd2, 32'h20, 32'h100, 3'b001, K_BRANCH, 1'b0, 4'd11);
      run_single("beq", 32'd1, 32'd2, 32'h20, 32'h100, 3'b000, K_BRANCH, 1'b0, 4'd12);
      run_single("bge", 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFF0, 32'h200, 3'b101, K_BRANCH, 1'b0, 4'd13);
      run_single("jalr", 32'h201, 32'd0, 32'd0, 32'h300, 3'b000, K_JALR, 1'b0, 4'd14);
      run_single("jal", 32'd0, 32'd0, 32'h0000_0800, 32'h304, 3'b000, K_JAL, 1'b0, 4'd15);
      run_single("lui", 32'd9, 32'hABCD_E000, 32'd0, 32'h308, 3'b000, K_LUI, 1'b0, 4'd1);
      run_single("auipc", 32'd0, 32'd0, 32'h0001_0000, 32'h30c, 3'b000, K_AUIPC, 1'b0, 4'd2);
      run_single("other", 32'd3, 32'd4, 32'd8, 32'h310, 3'b000, K_LOAD, 1'b0, 4'd0);

      // Literal spot-checks independent of the reference function.
      ref_exec(32'd5, 32'd7, 32'd0, 32'h40, 3'b000, K_OP, 1'b0, er, en);
      check("lit_add", 64'(er), 64'd12);
      sh_a = 32'h8000_0000;
      ref_exec(sh_a, 32'd4, 32'd0, 32'h0, 3'b101, K_OP, 1'b1, er, en);
      check("lit_sra", 64'(er), 64'hF800_0000);

      // ---------------- back-pressure ----------------
      bus.cdb_grant = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 32'(i * 10), 32'd1, 32'd0, 32'h400, 3'b000, K_OP, 1'b0, ROB_BIT'(i));
         tick();
         check($sformatf("bp_full_%0d", i), 64'(bus.alu_full), 64'(i >= 4));
      end
      bus.start_alu = 1'b0;
      bus.cdb_grant = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("bp_rdy_%0d", k), 64'(bus.alu_ready), 64'd1);
         check($sformatf("bp_tag_%0d", k), 64'(bus.finished_alu_rob_entry), 64'(k));
         check($sformatf("bp_res_%0d", k), 64'(bus.alu_result), 64'(k * 10 + 1));
         tick();
      end
      check("bp_drained", 64'(bus.alu_ready), 64'd0);
      check("bp_full_end", 64'(bus.alu_full), 64'd0);

      // ---------------- flush ----------------
      bus.cdb_grant = 1'b0;
      for (int i = 7; i <= 9; i++) begin
         drive(1'b1, 32'(i), 32'd0, 32'd0, 32'h500, 3'b000, K_OP, 1'b0, ROB_BIT'(i));
         tick();
      end
      bus.start_alu = 1'b0;
      tick();
      check("fl_pre_rdy", 64'(bus.alu_ready), 64'd1);
      check("fl_pre_tag", 64'(bus.finished_alu_rob_entry), 64'd7);
      rob_clear_up  = 1'b1;
      bus.cdb_grant = 1'b1;
      drive(1'b1, 32'd1, 32'd1, 32'd0, 32'h600, 3'b000, K_OP, 1'b0, 4'd10);
      tick();
      rob_clear_up  = 1'b0;
      bus.start_alu = 1'b0;
      check("fl_rdy", 64'(bus.alu_ready), 64'd0);
      check("fl_full", 64'(bus.alu_full), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("fl_quiet_%0d", i), 64'(bus.alu_ready), 64'd0);
      end

      // ---------------- rdy_in freeze ----------------
      bus.cdb_grant = 1'b0;
      drive(1'b1, 32'd2, 32'd0, 32'd0, 32'h700, 3'b000, K_OP, 1'b0, 4'd2);
      tick();
      drive(1'b1, 32'd3, 32'd0, 32'd0, 32'h704, 3'b000, K_OP, 1'b0, 4'd3);
      tick();
      bus.start_alu = 1'b0;
      tick();
      check("rdy_pre_tag", 64'(bus.finished_alu_rob_entry), 64'd2);
      rdy_in        = 1'b0;
      bus.cdb_grant = 1'b1;
      drive(1'b1, 32'd11, 32'd0, 32'd0, 32'h708, 3'b000, K_OP, 1'b0, 4'd11);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("frz_rdy_%0d", i), 64'(bus.alu_ready), 64'd1);
         check($sformatf("frz_tag_%0d", i), 64'(bus.finished_alu_rob_entry), 64'd2);
         check($sformatf("frz_full_%0d", i), 64'(bus.alu_full), 64'd0);
      end
      rdy_in        = 1'b1;
      bus.start_alu = 1'b0;
      tick();
      check("thaw_rdy", 64'(bus.alu_ready), 64'd1);
      check("thaw_tag", 64'(bus.finished_alu_rob_entry), 64'd3);
      check("thaw_res", 64'(bus.alu_result), 64'd3);
      tick();
      check("thaw_empty", 64'(bus.alu_ready), 64'd0);

      // ---------------- randomized traffic vs model ----------------
      mq.delete();
      for (int n = 0; n < 300; n++) begin
         check_model("rnd");
         vis = (mq.size() > 0) && (cyc >= mq[0].vis);
         rg  = ($urandom_range(0, 3) != 0);
         rs  = ($urandom_range(0, 2) != 0) && (mq.size() < QD);
         ra  = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40));
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
         ri  = $urandom();
         rp  = $urandom() & 32'hFFFF_FFFC;
         rf  = 3'($urandom_range(0, 7));
         ro  = opc_tab[$urandom_range(0, 7)];
         rad = 1'($urandom_range(0, 1));
         rt  = ROB_BIT'($urandom_range(0, 15));
         bus.cdb_grant = rg;
         drive(rs, ra, rb, ri, rp, rf, ro, rad, rt);
         tick();
         if (rg && vis) void'(mq.pop_front());
         if (rs) begin
            ref_exec(ra, rb, ri, rp, rf, ro, rad, er, en);
            e.tag = rt;
            e.res = er;
            e.npc = en;
            e.vis = cyc + 1;
            mq.push_back(e);
         end
      end
      bus.start_alu = 1'b0;
      bus.cdb_grant = 1'b1;
      for (int n = 0; n < 12 && mq.size() > 0; n++) begin
         check_model("drn");
         vis = (mq.size() > 0) && (cyc >= mq[0].vis);
         tick();
         if (vis) void'(mq.pop_front());
      end
      check("drn_ready", 64'(bus.alu_ready), 64'd0);
      if (mq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", mq.size());
      end

      // ---------------- reset mid-operation ----------------
      bus.cdb_grant = 1'b0;
      drive(1'b1, 32'd21, 32'd0, 32'd0, 32'h800, 3'b000, K_OP, 1'b0, 4'd5);
      tick();
      drive(1'b1, 32'd22, 32'd0, 32'd0, 32'h804, 3'b000, K_OP, 1'b0, 4'd6);
      tick();
      bus.start_alu = 1'b0;
      check("mr_pre_rdy", 64'(bus.alu_ready), 64'd1);
      #2;
      rst_in = 1'b0;
      #1;
      check("mr_rdy", 64'(bus.alu_ready), 64'd0);
      check("mr_full", 64'(bus.alu_full), 64'd0);
      check("mr_tag", 64'(bus.finished_alu_rob_entry), 64'd0);
      check("mr_res", 64'(bus.alu_result), 64'd0);
      check("mr_npc", 64'(bus.next_pc), 64'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      tick();
      tick();
      check("mr_after", 64'(bus.alu_ready), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execution unit on the far end of the reservation-station issue interface: accepts one ready instruction per cycle (`start_alu` plus operands) and computes RV32I ALU, branch and jump results.
- Queues finished results and broadcasts them on the common result bus (`alu_ready`, `finished_alu_rob_entry`, `alu_result`, `next_pc`) to the RS, LSB and ROB, using a valid/grant handshake.
- Back-pressures the RS through `alu_full`.

Parameters:
- ROB_BIT, 4, width of ROB entry tags.
- QUEUE_DEPTH, 4, result queue entries; power of 2, at least 2.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  CPU ready; when low, all state freezes.
- rob_clear_up  in  1  mispredict flush.
- start_alu  in  1  issue strobe from RS.
- vi  in  32  operand 1 (rs1 value).
- vj  in  32  operand 2 (rs2 value, or immediate for OP-IMM/LUI).
- imm  in  32  sign-extended immediate (branch/JAL/JALR/AUIPC).
- inst_addr  in  32  instruction PC.
- op  in  3  funct3.
- op_type  in  7  opcode.
- op_addition  in  1  inst[30].
- alu_rob_entry  in  ROB_BIT  destination ROB tag.
- alu_full  out  1  issue not accepted this cycle.
- alu_ready  out  1  result valid at queue head.
- cdb_grant  in  1  bus accepts the head this cycle.
- finished_alu_rob_entry  out  ROB_BIT  tag of head.
- alu_result  out  32  rd value, or branch taken flag.
- next_pc  out  32  resolved next PC.

Behaviour:
- Reset (rst_in=0, async):
  - Execute register and queue empty.
  - alu_ready=0, alu_full=0, finished_alu_rob_entry=0, alu_result=0, next_pc=0.
- rdy_in=0: no state changes. Outputs hold; start_alu and cdb_grant are ignored.
- Accept rule: at a clock edge with start_alu=1, alu_full=0 and no flush, the inputs are latched into execute register E1 (valid bit e1_v).
  - start_alu while alu_full=1 is dropped; the RS must not do this.
- alu_full = (queue count + e1_v) >= QUEUE_DEPTH, computed combinationally from state.
- E1 result is computed combinationally and written to the queue tail at the next edge (e1_v clears unless refilled).
  - Latency: issue edge N; alu_ready high in the cycle after edge N+1.
  - Throughput: 1 per cycle while grants flow.
- Pop: at an edge with alu_ready=1 and cdb_grant=1, the head is removed.
  - Simultaneous push and pop at a full queue is legal; count is unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- Outputs are driven from the queue head. When the queue is empty they hold their last values; consumers must qualify with alu_ready.
- Opcode handling (all arithmetic mod 2^32; shift amount = vj[4:0]):
  - 0110011 OP: ADD/SUB (op_addition=1 → SUB), SLL, SLT, SLTU, XOR, SRL/SRA (op_addition selects SRA), OR, AND. next_pc = pc+4.
  - 0010011 OP-IMM: same ops with vj as operand 2. op_addition is honoured only for funct3=101 (SRAI); ADDI never subtracts.
  - 0110111 LUI: result = vj.
  - 0010111 AUIPC: result = pc+imm.
  - 1100011 branch: BEQ, BNE, BLT, BGE, BLTU, BGEU. result = {31'b0, taken}; next_pc = taken ? pc+imm : pc+4.
  - 1101111 JAL: result = pc+4; next_pc = pc+imm.
  - 1100111 JALR: result = pc+4; next_pc = (vi+imm) & ~1.
  - Any other opcode: result = 0; next_pc = pc+4.
- Flush: rob_clear_up=1 at an edge (with rdy_in=1) empties E1 and the queue.
  - Highest priority: a concurrent start_alu or grant in that cycle has no effect.
  - alu_ready=0 from the next cycle.
- Reset asserted mid-operation discards all in-flight results immediately.

Optional Feature:
- Macro ALU_BYPASS_EN.
- Defined: when the queue is empty and e1_v=1, the E1 result drives the outputs combinationally and alu_ready=1 in the same cycle.
  - If granted, the result is not enqueued. Latency drops to 1 edge.
  - Flush still squashes the bypassed result.
- Undefined: all results pass through the queue (latency 2 edges).

Test Plan:
- Reset, then issue ADD vi=5 vj=7 tag=3 with grant held 1 → one cycle after the second edge: alu_ready=1, tag=3, result=12, next_pc=pc+4; alu_ready falls after the pop.
- SUB vi=1 vj=2 → 0xFFFFFFFF; SRA vi=0x80000000 vj=4 → 0xF8000000; SRAI vs SRLI on the same operands differ only by op_addition.
- BNE vi=1 vj=2 pc=0x100 imm=0x20 → result=1, next_pc=0x120; BEQ on the same operands → result=0, next_pc=0x104; JALR vi=0x201 imm=0 → next_pc=0x200, result=pc+4.
- Grant held 0 while issuing 5 back-to-back ops → alu_full rises once 4 are held; the 5th strobe is ignored; raising grant drains tags in issue order.
- With 3 results queued, rob_clear_up=1 together with start_alu → queue empty next cycle, alu_ready=0, no late result emerges.
- rdy_in=0 for 3 cycles with results pending and grant=1 → outputs and count frozen; popping resumes when rdy_in returns to 1.
